// File: rtl/rns7_pkg.sv
// Shared constants, FSM states and thermometer-code helpers for mod-7 RNS channels.
package rns7_pkg;

  localparam int unsigned MOD     = 7;
  localparam int unsigned RES_W   = 3;
  localparam int unsigned THERM_W = 6;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  // Value v maps to its lowest v bits set.
  function automatic logic [THERM_W-1:0] bin2therm(input logic [RES_W-1:0] v);
    logic [THERM_W-1:0] t;
    t = '0;
    for (int i = 0; i < int'(THERM_W); i++) begin
      t[i] = (int'(v) > i);
    end
    return t;
  endfunction

  // Population count; only meaningful for well-formed thermometer codes.
  function automatic logic [RES_W-1:0] therm2bin(input logic [THERM_W-1:0] t);
    logic [RES_W-1:0] b;
    b = '0;
    for (int i = 0; i < int'(THERM_W); i++) begin
      b = b + RES_W'(t[i]);
    end
    return b;
  endfunction

endpackage

// File: rtl/rns7_therm_add.sv
// Combinational mod-7 adder operating entirely on 6-bit thermometer codes.
module rns7_therm_add
  import rns7_pkg::*;
(
  input  logic [THERM_W-1:0] a,
  input  logic [THERM_W-1:0] b,
  output logic [THERM_W-1:0] sum
);

  // ge vectors: bit n set when operand >= n (bit 0 always set).
  logic [THERM_W:0] a_ge;
  logic [THERM_W:0] b_ge;

  assign a_ge = {a, 1'b1};
  assign b_ge = {b, 1'b1};

  // Merge the two codes into the unreduced sum (0..12), then fold back by 7 if it wrapped.
  always_comb begin
    logic [2*THERM_W+1:0] s_ge;  // top bit stays 0; lets the fold index one past the max
    s_ge = '0;
    for (int i = 0; i <= int'(THERM_W); i++) begin
      for (int j = 0; j <= int'(THERM_W); j++) begin
        s_ge[i+j] = s_ge[i+j] | (a_ge[i] & b_ge[j]);
      end
    end
    sum = '0;
    for (int k = 0; k < int'(THERM_W); k++) begin
      sum[k] = s_ge[MOD] ? s_ge[k+int'(MOD)+1] : s_ge[k+1];
    end
  end

endmodule

// File: rtl/rns7_acc_ctrl.sv
// Frame-based mod-7 accumulator controller: FSM, operand counter, sticky error and handshakes.
module rns7_acc_ctrl
  import rns7_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RES_W-1:0]   in_res,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RES_W-1:0]   out_res,
  output logic [THERM_W-1:0] out_therm,
  output logic               busy,
  output logic               err
);

  state_e             state_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [THERM_W-1:0] acc_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               err_q;

  logic               illegal;
  logic [THERM_W-1:0] operand;
  logic [THERM_W-1:0] acc_sum;
  logic               fire;

  assign fire    = in_valid & in_ready_q;
  assign illegal = (in_res == RES_W'(MOD));
  // An illegal residue contributes nothing to the sum.
  assign operand = illegal ? '0 : bin2therm(in_res);

  rns7_therm_add u_add (
    .a   (acc_q),
    .b   (operand),
    .sum (acc_sum)
  );

  // Single-process FSM; handshake and status outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q  <= len;
            acc_q  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            if (len == '0) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
            end else begin
              state_q    <= StAccum;
              in_ready_q <= 1'b1;
            end
          end
        end
        StAccum: begin
          if (fire) begin
            acc_q <= acc_sum;
            cnt_q <= cnt_q - LEN_W'(1);
            if (illegal) begin
              err_q <= 1'b1;
            end
            if (cnt_q == LEN_W'(1)) begin
              state_q     <= StDone;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign out_therm = acc_q;
  assign out_res   = therm2bin(acc_q);

endmodule

// File: tb/tb_rns7_acc_ctrl.sv
// Self-checking bench for rns7_acc_ctrl: directed frames plus randomized frames vs. a sum model.
module tb_rns7_acc_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_res;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_res;
  logic [5:0] out_therm;
  logic       busy;
  logic       err;

  int checks   = 0;
  int failures = 0;
  int res_q[$];

  rns7_acc_ctrl #(.LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_res    (in_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_therm (out_therm),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; both sampling and driving happen 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] therm_of(input int v);
    logic [6:0] t;
    t = (7'd1 << v) - 7'd1;
    return t[5:0];
  endfunction

  task automatic check_reset_values(input string name);
    check_eq({name, "/busy"}, 32'(busy), 0);
    check_eq({name, "/in_ready"}, 32'(in_ready), 0);
    check_eq({name, "/out_valid"}, 32'(out_valid), 0);
    check_eq({name, "/err"}, 32'(err), 0);
    check_eq({name, "/out_res"}, 32'(out_res), 0);
    check_eq({name, "/out_therm"}, 32'(out_therm), 0);
  endtask

  // Runs one frame of n operands taken from res_q; gap_pct = chance of an idle in_valid cycle,
  // bp = cycles of out_ready held low once the result is up.
  task automatic run_frame(input string name, input int n, input int gap_pct, input int bp);
    int  idx;
    int  cyc;
    int  budget;
    int  exp_sum;
    bit  exp_err;
    bit  fire;
    check_eq({name, "/idle_busy"}, 32'(busy), 0);
    start = 1'b1;
    len   = 8'(n);
    step();
    start   = 1'b0;
    exp_sum = 0;
    exp_err = 1'b0;
    check_eq({name, "/busy_rise"}, 32'(busy), 1);
    idx    = 0;
    cyc    = 0;
    budget = n * 20 + 50;
    while (idx < n && cyc < budget) begin
      check_eq({name, "/in_ready"}, 32'(in_ready), 1);
      check_eq({name, "/no_early_valid"}, 32'(out_valid), 0);
      // Stray start pulses during the frame must be ignored.
      start    = (cyc == 0) || ($urandom_range(3) == 0);
      len      = 8'($urandom_range(255));
      in_valid = ($urandom_range(99) >= gap_pct);
      in_res   = in_valid ? 3'(res_q[idx]) : 3'($urandom_range(7));
      fire     = in_valid && in_ready;
      step();
      if (fire) begin
        if (res_q[idx] == 7) exp_err = 1'b1;
        else exp_sum = (exp_sum + res_q[idx]) % 7;
        idx++;
      end
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check_eq({name, "/handshakes"}, 32'(idx), 32'(n));
    for (int b = 0; b <= bp; b++) begin
      out_ready = (b == bp);
      check_eq({name, "/out_valid"}, 32'(out_valid), 1);
      check_eq({name, "/in_ready_done"}, 32'(in_ready), 0);
      check_eq({name, "/out_res"}, 32'(out_res), 32'(exp_sum));
      check_eq({name, "/out_therm"}, 32'(out_therm), 32'(therm_of(exp_sum)));
      check_eq({name, "/err"}, 32'(err), 32'(exp_err));
      step();
    end
    out_ready = 1'b0;
    check_eq({name, "/back_idle_valid"}, 32'(out_valid), 0);
    check_eq({name, "/back_idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_res    = '0;
    out_ready = 1'b0;
    #12;
    check_reset_values("reset");
    rst_n = 1'b1;
    step();
    check_reset_values("post_reset");

    res_q = '{5, 4, 6};
    run_frame("basic", 3, 0, 0);
    res_q = '{};
    run_frame("empty", 0, 0, 2);
    res_q = '{6, 6, 6, 6};
    run_frame("gaps", 4, 50, 1);
    res_q = '{7, 2};
    run_frame("illegal", 2, 0, 5);

    // Abort a 5-operand frame after 2 handshakes.
    start = 1'b1;
    len   = 8'd5;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_res   = 3'd1;
    step();
    in_res = 3'd2;
    step();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_values("mid_reset");
    step();
    rst_n = 1'b1;
    step();
    res_q = '{3};
    run_frame("after_reset", 1, 0, 0);

    for (int f = 0; f < 40; f++) begin
      n     = $urandom_range(12);
      res_q = '{};
      for (int i = 0; i < n; i++) begin
        res_q.push_back(($urandom_range(7) == 0) ? 7 : $urandom_range(6));
      end
      run_frame($sformatf("rand%0d", f), n, $urandom_range(60), $urandom_range(3));
      if ($urandom_range(1) == 1) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
